// File: rtl/vdp_bus_master.sv
// vdp_bus_master: turns single-byte commands into timed mode/write/read strobe cycles on the VDP host port.
// Define VDP_BUS_READ_EN to enable the READ (op 100) bus cycle; without it op 100 is illegal.
module vdp_bus_master #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       err,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [1:0] vdp_mode,
    output logic       vdp_write,
    output logic       vdp_read,
    output logic [7:0] vdp_data_out,
    input  logic [7:0] vdp_data_in
);
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
    localparam logic [2:0] OP_WRREG  = 3'd1;
    localparam logic [2:0] OP_WRVRAM = 3'd2;
    localparam logic [2:0] OP_SETREG = 3'd3;
    localparam logic [2:0] OP_READ   = 3'd4;
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LD  = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    if (SETUP_CYC < 1 || SETUP_CYC > 15 || PULSE_CYC < 1 || PULSE_CYC > 15 ||
        HOLD_CYC < 1 || HOLD_CYC > 15) begin : g_bad_cfg
        $error("vdp_bus_master: SETUP_CYC, PULSE_CYC and HOLD_CYC must each be 1..15");
    end
    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       live, phase2, err_q, legal, accept, last, chain;
    logic [2:0] op_q;
    logic [1:0] mode_q, mode_sel;
    logic [7:0] dout_q, byte2_q;
`ifdef VDP_BUS_READ_EN
    assign legal = cmd_op <= OP_READ;
`else
    assign legal = cmd_op < OP_READ;
`endif
    assign accept   = cmd_valid && cmd_ready;
    assign last     = cnt == 4'd0;
    assign chain    = state == HOLD && last && op_q == OP_SETREG && !phase2;
    assign mode_sel = cmd_op == OP_WRREG ? 2'b01 : cmd_op == OP_WRVRAM ? 2'b10 :
                      cmd_op == OP_READ ? 2'b11 : 2'b00;
    // State and phase counter registers; reset aborts any transaction at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // Next state: walk SETUP -> PULSE -> HOLD, reloading the counter on each entry.
    always_comb begin
        state_nx = state;
        cnt_nx   = last ? cnt : cnt - 4'd1;
        case (state)
            IDLE: begin
                cnt_nx = cnt;
                if (accept && legal) begin
                    state_nx = SETUP;
                    cnt_nx   = SETUP_LD;
                end
            end
            SETUP: if (last) begin
                state_nx = PULSE;
                cnt_nx   = PULSE_LD;
            end
            PULSE: if (last) begin
                state_nx = HOLD;
                cnt_nx   = HOLD_LD;
            end
            default: if (last) begin
                state_nx = chain ? SETUP : IDLE;
                cnt_nx   = chain ? SETUP_LD : cnt;
            end
        endcase
    end
    // Command latch and bus mode/data registers; mode/data persist through IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live    <= 1'b0;
            err_q   <= 1'b0;
            phase2  <= 1'b0;
            op_q    <= 3'd0;
            byte2_q <= 8'd0;
            mode_q  <= 2'b00;
            dout_q  <= 8'd0;
        end else begin
            live  <= 1'b1;
            err_q <= accept && !legal;
            if (accept && legal) begin
                op_q    <= cmd_op;
                byte2_q <= cmd_data;
                phase2  <= 1'b0;
                mode_q  <= mode_sel;
                dout_q  <= cmd_op == OP_SETREG ? cmd_addr : cmd_data;
            end else if (chain) begin
                phase2 <= 1'b1;
                mode_q <= 2'b01;
                dout_q <= byte2_q;
            end
        end
    end
    assign cmd_ready    = live && state == IDLE;
    assign busy         = state != IDLE;
    assign err          = err_q;
    assign vdp_mode     = mode_q;
    assign vdp_data_out = dout_q;
    assign vdp_write    = state == PULSE && op_q != OP_READ;
`ifdef VDP_BUS_READ_EN
    logic [7:0] rsp_q;
    // Capture read data on the final PULSE cycle, while the VDP still drives it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rsp_q <= 8'd0;
        else if (state == PULSE && last && op_q == OP_READ) rsp_q <= vdp_data_in;
    end
    assign vdp_read  = state == PULSE && op_q == OP_READ;
    assign rsp_valid = state == HOLD && last && op_q == OP_READ;
    assign rsp_data  = rsp_q;
`else
    logic unused_rd;
    assign unused_rd = ^vdp_data_in;
    assign vdp_read  = 1'b0;
    assign rsp_valid = 1'b0;
    assign rsp_data  = 8'd0;
`endif
endmodule

// File: tb/tb_vdp_bus_master.sv
// tb_vdp_bus_master: directed and randomized checks of vdp_bus_master against a cycle-trace model.
module tb_vdp_bus_master;
    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 1;
    localparam int T = S + P + H;
`ifdef VDP_BUS_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_addr = 8'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       busy, err, rsp_valid, vdp_write, vdp_read;
    logic [7:0] rsp_data, vdp_data_out;
    logic [7:0] vdp_data_in = 8'd0;
    logic [1:0] vdp_mode;
    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] prev_mode = 2'b00;
    logic [7:0] prev_dout = 8'd0;
    logic [7:0] last_rsp = 8'd0;

    vdp_bus_master #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy),
        .err(err), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .vdp_mode(vdp_mode),
        .vdp_write(vdp_write), .vdp_read(vdp_read), .vdp_data_out(vdp_data_out),
        .vdp_data_in(vdp_data_in)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_mode", vdp_mode, 0);
        chk("rst_write", vdp_write, 0);
        chk("rst_read", vdp_read, 0);
        chk("rst_dout", vdp_data_out, 0);
    endtask

    // Issue one command at a negedge with cmd_ready high and check the whole bus trace.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] rd;
        logic [1:0] em;
        logic [7:0] ed;
        bit legal, rdop, on;
        int np, ph, k;
        rd    = 8'($urandom);
        legal = op < 3'd4 || (op == 3'd4 && READ_EN);
        rdop  = op == 3'd4 && legal;
        np    = op == 3'd3 ? 2 : 1;
        chk("ready_before", cmd_ready, 1);
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        vdp_data_in = 8'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_addr = 8'($urandom); cmd_data = 8'($urandom);
        if (!legal) begin
            chk("illegal_err", err, 1);
            chk("illegal_busy", busy, 0);
            chk("illegal_write", vdp_write, 0);
            chk("illegal_read", vdp_read, 0);
            chk("illegal_ready", cmd_ready, 1);
            chk("illegal_mode", vdp_mode, prev_mode);
            chk("illegal_dout", vdp_data_out, prev_dout);
            @(negedge clk);
            chk("illegal_err_end", err, 0);
            chk("illegal_busy_end", busy, 0);
            return;
        end
        for (int c = 0; c < np * T; c++) begin
            ph = c / T;
            k  = c % T;
            em = op == 3'd3 ? (ph == 1 ? 2'b01 : 2'b00) : op == 3'd1 ? 2'b01 :
                 op == 3'd2 ? 2'b10 : op == 3'd4 ? 2'b11 : 2'b00;
            ed = (op == 3'd3 && ph == 0) ? a : d;
            on = k >= S && k < S + P;
            if (k == S + P - 1) vdp_data_in = rd;
            if (k == S + P) vdp_data_in = ~rd;
            chk("tr_mode", vdp_mode, em);
            chk("tr_dout", vdp_data_out, ed);
            chk("tr_write", vdp_write, on && !rdop);
            chk("tr_read", vdp_read, on && rdop);
            chk("tr_busy", busy, 1);
            chk("tr_ready", cmd_ready, 0);
            chk("tr_err", err, 0);
            chk("tr_rsp_valid", rsp_valid, rdop && k == T - 1 && ph == np - 1);
            @(negedge clk);
        end
        if (rdop) last_rsp = rd;
        prev_mode = em;
        prev_dout = ed;
        chk("end_ready", cmd_ready, 1);
        chk("end_busy", busy, 0);
        chk("end_write", vdp_write, 0);
        chk("end_read", vdp_read, 0);
        chk("end_rsp_valid", rsp_valid, 0);
        chk("end_mode", vdp_mode, prev_mode);
        chk("end_dout", vdp_data_out, prev_dout);
        chk("end_rsp_data", rsp_data, READ_EN ? last_rsp : 8'd0);
    endtask

    initial begin
        logic [7:0] vals [3];
        int idx, npulse, last_c;
        bit pend, prev_w;
        // reset held with a command offered
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        chk_idle_zero();
        cmd_valid = 1'b0;
        reset = 1'b0;
        #1 chk("release_ready_pre", cmd_ready, 0);
        @(negedge clk);
        chk("release_ready", cmd_ready, 1);
        chk("release_write", vdp_write, 0);
        // directed commands
        do_cmd(3'd0, 8'h00, 8'h05);
        do_cmd(3'd3, 8'h04, 8'h3F);
        do_cmd(3'd4, 8'h00, 8'h00);
        do_cmd(3'd7, 8'h12, 8'h34);
        // WRVRAM burst with cmd_valid held
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        cmd_op = 3'd2; cmd_data = vals[0]; cmd_valid = 1'b1;
        idx = 0; pend = 0; npulse = 0; last_c = 0; prev_w = 0;
        for (int c = 0; c < 20; c++) begin
            if (pend) begin
                idx++;
                if (idx < 3) cmd_data = vals[idx];
                else cmd_valid = 1'b0;
            end
            pend = cmd_ready && cmd_valid;
            if (vdp_write && !prev_w) begin
                if (npulse < 3) chk("burst_data", vdp_data_out, vals[npulse]);
                chk("burst_mode", vdp_mode, 2'b10);
                if (npulse > 0) chk("burst_gap", c - last_c, T + 1);
                last_c = c;
                npulse++;
            end
            prev_w = vdp_write;
            @(negedge clk);
        end
        chk("burst_count", npulse, 3);
        prev_mode = 2'b10;
        prev_dout = 8'h33;
        // randomized commands
        for (int i = 0; i < 40; i++) begin
            do_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        // reset during PULSE of WRREG
        cmd_op = 3'd1; cmd_data = 8'h5A; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_write_on", vdp_write, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_write_drop", vdp_write, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", cmd_ready, 0);
        @(negedge clk);
        chk_idle_zero();
        reset = 1'b0;
        #1 chk("mid_ready_pre", cmd_ready, 0);
        @(negedge clk);
        chk("mid_ready_release", cmd_ready, 1);
        prev_mode = 2'b00;
        prev_dout = 8'd0;
        last_rsp  = 8'd0;
        do_cmd(3'd7, 8'hAA, 8'h55);
        do_cmd(3'd1, 8'h00, 8'hC3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
